// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional auto-repeat is compiled in with the KEYPAD_REPEAT_EN macro (see keypad_scan.sv).
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;

  // Debounce FSM encoding, also driven out on dbg_state
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Classification of one complete scan
  typedef enum logic [1:0] {SNAP_NONE, SNAP_SINGLE, SNAP_MULTI} snap_class_e;

  typedef struct packed {
    snap_class_e            cls;
    logic [KP_CODE_W-1:0]   code;
  } snap_t;

  function automatic int kp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Count pressed keys (bit set = pressed) and report the code when exactly one is down
  function automatic snap_t kp_classify(input logic [KP_ROWS*KP_COLS-1:0] keys);
    snap_t r;
    int    n;
    r.cls  = SNAP_NONE;
    r.code = '0;
    n      = 0;
    for (int i = 0; i < KP_ROWS*KP_COLS; i++) begin
      if (keys[i]) begin
        n      = n + 1;
        r.code = KP_CODE_W'(i);
      end
    end
    if (n == 1)     r.cls = SNAP_SINGLE;
    else if (n > 1) r.cls = SNAP_MULTI;
    return r;
  endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row rotation for the keypad: one row driven low at a time, ROW_DWELL cycles each.
// sample marks the last dwell cycle of every row; scan_end marks it for row 3.
module keypad_row_driver
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL = 50000
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [KP_ROWS-1:0] row_n,
  output logic [1:0]         row_idx,
  output logic               sample,
  output logic               scan_end
);

  localparam int             DW         = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(ROW_DWELL - 1);

  logic [DW-1:0] dwell_q;

  assign sample   = (dwell_q == DWELL_LAST);
  assign scan_end = sample && (row_idx == 2'd3);

  // Dwell counter and one-hot-low row rotation 1110 -> 1101 -> 1011 -> 0111
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dwell_q <= '0;
      row_idx <= 2'd0;
      row_n   <= 4'b1110;
    end else if (sample) begin
      dwell_q <= '0;
      row_idx <= row_idx + 2'd1;
      row_n   <= {row_n[2:0], row_n[3]};
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad front end: column sync, whole-scan debounce FSM and a one-entry
// valid/ready output buffer. Define KEYPAD_REPEAT_EN to add auto-repeat while held.
//
// Handshake: a code moves to the consumer on every rising clk edge where
// key_valid && key_ready; key_valid stays high and key_code stable until then.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL          = 50000,
  parameter int DEBOUNCE_SCANS     = 20,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [KP_COLS-1:0]   col_n,
  output logic [KP_ROWS-1:0]   row_n,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_down,
  output logic                 overflow,
  output logic [1:0]           dbg_state
);

  // One width covers the debounce count and the repeat count
  localparam int CW = $clog2(kp_max(DEBOUNCE_SCANS,
                                    kp_max(REPEAT_DELAY_SCANS, REPEAT_RATE_SCANS)) + 1);

  logic [KP_COLS-1:0]   col_meta, col_sync;
  logic [1:0]           row_idx;
  logic                 sample, scan_end;
  logic [11:0]          snap_q;
  snap_t                snap;
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [KP_CODE_W-1:0] cand_q, cand_d;
  logic                 emit, xfer;
`ifdef KEYPAD_REPEAT_EN
  logic [CW-1:0]        rep_q, rep_d, rep_inc;
  logic                 rep_first_q, rep_first_d;
`endif

  keypad_row_driver #(.ROW_DWELL(ROW_DWELL)) u_rows (
    .clk      (clk),
    .rstn     (rstn),
    .row_n    (row_n),
    .row_idx  (row_idx),
    .sample   (sample),
    .scan_end (scan_end)
  );

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Capture rows 0..2 as pressed-high bits; row 3 is used live at scan_end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_q <= '0;
    end else if (sample) begin
      case (row_idx)
        2'd0:    snap_q[3:0]  <= ~col_sync;
        2'd1:    snap_q[7:4]  <= ~col_sync;
        2'd2:    snap_q[11:8] <= ~col_sync;
        default: ;
      endcase
    end
  end

  assign snap      = kp_classify({~col_sync, snap_q});
  assign cnt_inc   = cnt_q + 1'b1;
  assign dbg_state = state_q;
  assign xfer      = key_valid && key_ready;
`ifdef KEYPAD_REPEAT_EN
  assign rep_inc   = rep_q + 1'b1;
`endif

  // Debounce FSM; every decision is taken on scan_end only
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    if (scan_end) begin
      case (state_q)
        ST_IDLE: begin
          if (snap.cls == SNAP_SINGLE) begin
            cand_d = snap.code;
            if (DEBOUNCE_SCANS <= 1) begin
              emit    = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
              rep_first_d = 1'b1;
`endif
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (snap.cls == SNAP_SINGLE && snap.code == cand_q) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              emit    = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
              rep_first_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (snap.cls == SNAP_NONE) begin
            state_d = (DEBOUNCE_SCANS <= 1) ? ST_IDLE : ST_RELEASE;
            cnt_d   = (DEBOUNCE_SCANS <= 1) ? '0 : CW'(1);
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // First repeat after the delay, later ones at the rate
            if (rep_inc == (rep_first_q ? CW'(REPEAT_DELAY_SCANS) : CW'(REPEAT_RATE_SCANS))) begin
              emit        = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b0;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
        default: begin // ST_RELEASE
          if (snap.cls == SNAP_NONE) begin
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // FSM registers; key_down follows the next state on the same edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      key_down <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      key_down <= (state_d == ST_HELD) || (state_d == ST_RELEASE);
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  // Single-entry output buffer with sticky overflow on a dropped code
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!key_valid || key_ready) begin
        key_code  <= cand_d;
        key_valid <= 1'b1;
        if (xfer) overflow <= 1'b0;
      end else begin
        overflow <= 1'b1;
      end
    end else if (xfer) begin
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a 16-cycle scan (ROW_DWELL=4, DEBOUNCE_SCANS=3).
// Keys change only on scan boundaries; a scan-level reference model predicts
// every output each cycle, and delivered codes are matched against exp_q.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int DWELL = 4;
  localparam int DS    = 3;
  localparam int RDLY  = 6;
  localparam int RRATE = 2;
  localparam int SCAN  = 4 * DWELL;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic [3:0] key_code;
  logic       key_down;
  logic       overflow;
  logic [1:0] dbg_state;

  logic [15:0] keys = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  keypad_scan #(
    .ROW_DWELL(DWELL), .DEBOUNCE_SCANS(DS),
    .REPEAT_DELAY_SCANS(RDLY), .REPEAT_RATE_SCANS(RRATE)
  ) dut (
    .clk(clk), .rstn(rstn), .col_n(col_n), .row_n(row_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_down(key_down), .overflow(overflow), .dbg_state(dbg_state)
  );

  // Physical matrix: a column reads low when a pressed key sits on a driven row
  always_comb begin
    col_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && row_n[r] === 1'b0) col_n[c] = 1'b0;
  end

  // ---------------- reference model state ----------------
  int         k;          // clock edges since reset release
  logic       m_valid, m_ovf, m_down;
  logic [3:0] m_code, cand;
  int         run, rel, rep, rep_target;
  logic [3:0] exp_q[$];
  int         rdy_mode;   // 0: ready high, 1: ready low, 2: random
  logic       rdy_cur = 1'b0;
  int         pulses;
  logic       prev_valid, down_seen;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // One whole scan of the current key set, judged by the debounce rules
  task automatic model_scan(output logic e, output logic [3:0] ec);
    int n;
    logic [3:0] c;
    n = 0; c = '0; e = 1'b0;
    for (int i = 0; i < 16; i++) if (keys[i]) begin n++; c = i[3:0]; end
    if (!m_down) begin
      if (run > 0) begin
        if (n == 1 && c == cand) run++; else run = 0;
      end else if (n == 1) begin
        cand = c; run = 1;
      end
      if (run == DS) begin
        e = 1'b1; m_down = 1'b1; run = 0; rep = 0; rep_target = RDLY;
      end
    end else if (rel > 0) begin
      if (n == 0) begin
        rel++;
        if (rel == DS) begin m_down = 1'b0; rel = 0; end
      end else begin
        rel = 0;
      end
    end else if (n == 0) begin
      rel = 1;
      if (rel == DS) begin m_down = 1'b0; rel = 0; end
    end else begin
`ifdef KEYPAD_REPEAT_EN
      rep++;
      if (rep == rep_target) begin e = 1'b1; rep = 0; rep_target = RRATE; end
`endif
    end
    ec = cand;
  endtask

  // Advance one clock: score transfers, update model, compare every output
  task automatic tick();
    logic       e, xfer_dut, xfer_m;
    logic [3:0] ec, code_dut, exp_row;
    logic [1:0] exp_state;
    xfer_dut = key_valid && rdy_cur;
    code_dut = key_code;
    @(negedge clk);
    k++;
    if (xfer_dut) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL delivered_code cycle %0d: got %h expected none", k, code_dut);
      end else begin
        check("delivered_code", 16'(code_dut), 16'(exp_q.pop_front()));
      end
    end
    e = 1'b0; ec = '0;
    if (k % SCAN == 0) model_scan(e, ec);
    xfer_m = m_valid && rdy_cur;
    if (e) begin
      if (!m_valid || rdy_cur) begin
        m_code = ec; m_valid = 1'b1; exp_q.push_back(ec);
        if (xfer_m) m_ovf = 1'b0;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (xfer_m) begin
      m_valid = 1'b0; m_ovf = 1'b0;
    end
    exp_row   = 4'hf ^ (4'b0001 << ((k / DWELL) % 4));
    exp_state = !m_down ? ((run > 0) ? ST_DEBOUNCE : ST_IDLE)
                        : ((rel > 0) ? ST_RELEASE : ST_HELD);
    check("row_n",     16'(row_n),     16'(exp_row));
    check("key_valid", 16'(key_valid), 16'(m_valid));
    check("key_code",  16'(key_code),  16'(m_code));
    check("overflow",  16'(overflow),  16'(m_ovf));
    check("key_down",  16'(key_down),  16'(m_down));
    check("state",     16'(dbg_state), 16'(exp_state));
    if (key_valid && !prev_valid) pulses++;
    prev_valid = key_valid;
    if (key_down) down_seen = 1'b1;
    case (rdy_mode)
      0:       rdy_cur = 1'b1;
      1:       rdy_cur = 1'b0;
      default: rdy_cur = 1'($urandom_range(0, 1));
    endcase
    key_ready = rdy_cur;
  endtask

  // ---------------- driver tasks ----------------
  task automatic scans(input logic [15:0] v, input int n);
    while (k % SCAN != 0) tick();
    keys = v;
    repeat (SCAN * n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    k = 0; m_valid = 0; m_ovf = 0; m_down = 0; m_code = '0; cand = '0;
    run = 0; rel = 0; rep = 0; rep_target = RDLY; prev_valid = 0;
    exp_q.delete();
    rstn = 1'b1;
    rdy_cur = (rdy_mode != 1);
    key_ready = rdy_cur;
    check("reset_row_n",     16'(row_n),     16'h000e);
    check("reset_key_valid", 16'(key_valid), 16'h0);
    check("reset_key_code",  16'(key_code),  16'h0);
    check("reset_key_down",  16'(key_down),  16'h0);
    check("reset_overflow",  16'(overflow),  16'h0);
    check("reset_state",     16'(dbg_state), 16'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, b, kind, len;
    logic [15:0] v;
    rdy_mode = 0;
    do_reset();
    repeat (DWELL) tick();
    check("row_after_dwell", 16'(row_n), 16'h000d);

    // Clean press of code 9 (row 2, col 1)
    pulses = 0;
    scans(16'h0200, 2);
    check("press_down_early", 16'(key_down), 16'h0);
    scans(16'h0200, 1);
    check("press_down",  16'(key_down),  16'h1);
    check("press_valid", 16'(key_valid), 16'h1);
    check("press_code",  16'(key_code),  16'h9);
    scans(16'h0200, 2);
    check("press_one_pulse", 16'(pulses), 16'd1);
    scans(16'h0000, 2);
    check("release_down_held", 16'(key_down), 16'h1);
    scans(16'h0000, 1);
    check("release_down_clear", 16'(key_down), 16'h0);

    // Bounce: too short to be accepted
    pulses = 0; down_seen = 1'b0;
    scans(16'h0200, 2);
    scans(16'h0000, 4);
    check("bounce_pulses", 16'(pulses), 16'd0);
    check("bounce_down",   16'(down_seen), 16'h0);

    // Ghosting: codes 0 and 5 together
    pulses = 0;
    scans(16'h0021, 6);
    check("ghost_pulses", 16'(pulses), 16'd0);
    check("ghost_state",  16'(dbg_state), 16'(ST_IDLE));
    scans(16'h0000, 1);

    // Backpressure: code 3 buffered, code 12 dropped
    rdy_mode = 1;
    scans(16'h0008, 3);
    scans(16'h0000, 3);
    scans(16'h1000, 3);
    check("bp_valid",    16'(key_valid), 16'h1);
    check("bp_code",     16'(key_code),  16'h3);
    check("bp_overflow", 16'(overflow),  16'h1);
    scans(16'h0000, 3);
    rdy_mode = 0; tick();
    rdy_mode = 1; tick();
    check("bp_drain_valid",    16'(key_valid), 16'h0);
    check("bp_drain_overflow", 16'(overflow),  16'h0);
    check("bp_code_held",      16'(key_code),  16'h3);

    // Reset while a code is pending aborts it immediately
    scans(16'h0020, 3);
    check("abort_pending", 16'(key_valid), 16'h1);
    #2 rstn = 1'b0;
    #1;
    check("abort_valid", 16'(key_valid), 16'h0);
    check("abort_code",  16'(key_code),  16'h0);
    check("abort_down",  16'(key_down),  16'h0);
    check("abort_row_n", 16'(row_n),     16'h000e);
    rdy_mode = 0;
    do_reset();

    // Long hold of code 7
    pulses = 0;
    scans(16'h0080, 12);
`ifdef KEYPAD_REPEAT_EN
    check("hold_pulses", 16'(pulses), 16'd3);
`else
    check("hold_pulses", 16'(pulses), 16'd1);
`endif
    scans(16'h0000, 4);

    // Randomized key traffic and random consumer readiness
    rdy_mode = 2;
    repeat (150) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      v    = 16'h0000;
      if (kind == 1 || kind == 2) v = 16'h0001 << a;
      else if (kind == 3) v = (16'h0001 << a) | (16'h0001 << b);
      else if (kind == 4) v = 16'h0001 << (len > 3 ? b : a);
      scans(v, len);
    end
    rdy_mode = 0;
    scans(16'h0000, 4);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
